// File: rtl/controle_somador_serial.sv
// Serial add/subtract sequencer: one shared 4-bit adder, one nibble per clock.
// Ports: clk, rst_n (sync, active-low), start/sub/a/b in; busy/done/s/cout/ovf out.

// somador4b: plain 4-bit full adder slice (a + b + cin).
// Ports: a, b (4b), cin in; s (4b), cout out.
module somador4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module controle_somador_serial #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] s,
    output logic                 cout,
    output logic                 ovf
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES);
    localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    s_q, s_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic [3:0]      add_a, add_b, add_s;
    logic            add_co;

    // {idx, 2'b00} is idx*4 at exactly the width needed
    assign add_a = a_q[{idx_q, 2'b00} +: 4];
    assign add_b = b_q[{idx_q, 2'b00} +: 4];

    somador4b u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // b is stored already inverted for subtract; cin=1 completes ~b+1
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    idx_d   = '0;
                    s_d     = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[{idx_q, 2'b00} +: 4] = add_s;
                carry_d = add_co;
                if (idx_q == LAST) begin
                    cout_d  = add_co;
                    ovf_d   = ~(a_q[W-1] ^ b_q[W-1]) & (add_s[3] ^ a_q[W-1]);
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_controle_somador_serial.sv
// Directed bench for controle_somador_serial with NIBBLES=4.
// Checks latency, handshake, arithmetic flags, hold and reset behaviour.

module tb_controle_somador_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        cout;
    logic        ovf;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    controle_somador_serial #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: plain; 1: scramble inputs during RUN; 2: pulse start in RUN/DONE
    task automatic run_op(input string tag, input logic [15:0] ta,
                          input logic [15:0] tb_, input logic tsub,
                          input logic [15:0] es, input logic ec,
                          input logic eo, input int mode);
        a = ta;
        b = tb_;
        sub = tsub;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, " busy"}, busy, 1);
            chk({tag, " nodone"}, done, 0);
            if (mode == 1) begin
                a = ~ta;
                b = 16'h5a5a;
                sub = ~tsub;
            end
            start = (mode == 2 && (i == 1 || i == 2));
            tick();
        end
        chk({tag, " done"}, done, 1);
        chk({tag, " busy0"}, busy, 0);
        chk({tag, " s"}, s, es);
        chk({tag, " cout"}, cout, ec);
        chk({tag, " ovf"}, ovf, eo);
        start = (mode == 2);
        tick();
        start = 1'b0;
        chk({tag, " done0"}, done, 0);
        chk({tag, " idle"}, busy, 0);
        chk({tag, " hold_s"}, s, es);
        tick();
        chk({tag, " no_accept"}, busy, 0);
    endtask

    initial begin
        int first_done;
        int second_done;
        rst_n = 1'b0;
        start = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst s", s, 0);
        chk("rst cout", cout, 0);
        chk("rst ovf", ovf, 0);
        rst_n = 1'b1;
        tick();

        run_op("add1", 16'h1234, 16'h4321, 0, 16'h5555, 0, 0, 0);
        run_op("carry", 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 0);
        run_op("povf", 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 0);
        run_op("novf", 16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1, 0);
        run_op("borrow", 16'h0005, 16'h0007, 1, 16'hFFFE, 0, 0, 1);
        run_op("ignore", 16'h0100, 16'h0023, 0, 16'h0123, 0, 0, 2);

        // start held high: done pulses exactly 6 cycles apart
        first_done = -1;
        second_done = -1;
        a = 16'h0001;
        b = 16'h0002;
        sub = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (done) begin
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
        end
        start = 1'b0;
        chk("b2b first", first_done, 5);
        chk("b2b second", second_done, 11);
        chk("b2b s", s, 16'h0003);
        for (int c = 0; c < 8; c++) tick();
        chk("b2b drained", busy, 0);

        // reset after nibble 1 has been written
        a = 16'h1111;
        b = 16'h1111;
        sub = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre-rst partial", s, 16'h0022);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst s", s, 0);
        chk("midrst cout", cout, 0);
        chk("midrst ovf", ovf, 0);
        tick();
        chk("midrst idle", busy, 0);
        run_op("post", 16'h0F0F, 16'h0101, 0, 16'h1010, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/controle_somador_serial.md
Name: controle_somador_serial

Overview:
- Multi-cycle sequencer that performs a NIBBLES*4-bit add or subtract by time-sharing a single somador4b instance, one nibble per clock.
- The carry between nibbles is held in a register.
- Sits between a requester (start/done handshake) and the shared 4-bit adder.
- Replaces a wide ripple chain where area matters more than latency.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  W  operand A; sampled with start.
- b  input  W  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, result valid.
- s  output  W  result (sum/difference).
- cout  output  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
  - While rst_n=0: state=IDLE, nibble index=0, carry reg=0, busy=0, done=0, s=0, cout=0, ovf=0.
  - Reset mid-operation aborts the operation; there is no resume.
- Datapath:
  - Exactly one somador4b instance.
  - Adder inputs: a nibble [idx], b' nibble [idx], cin = carry reg.
  - b' = b when sub=0; b' = ~b when sub=1.
  - On accept, carry reg is initialised to sub (two's-complement subtract).
  - Operands a and b' are captured into internal registers on accept; input changes after accept have no effect.
- FSM states:
  - IDLE: busy=0, done=0. If start=1, accept:
    - capture operands and sub;
    - carry reg <= sub; idx <= 0;
    - s <= 0, cout <= 0, ovf <= 0;
    - go to RUN.
  - RUN: busy=1. Each edge:
    - s[4*idx+3:4*idx] <= adder sum;
    - carry reg <= adder cout;
    - idx <= idx+1.
    - On the edge processing idx=NIBBLES-1:
      - cout <= adder cout;
      - ovf <= (A_msb XNOR B'_msb) AND (sum_msb XOR A_msb), where msb = bit W-1;
      - done <= 1;
      - go to DONE.
  - DONE: busy=0, done=1 for exactly this one cycle. Next edge: done <= 0, go to IDLE.
- Latency:
  - Start accepted at edge k; nibble i is written at edge k+1+i.
  - done is high in the cycle after edge k+NIBBLES.
  - Earliest next accept is at edge k+NIBBLES+2.
- Handshake and holding rules:
  - start asserted in RUN or DONE is ignored; it is not queued.
  - s, cout and ovf hold their values from the DONE cycle until the next accept.
  - busy and done are never high together.
  - start held high continuously produces back-to-back operations every NIBBLES+2 cycles.
- Width and arithmetic:
  - idx width = ceil(log2(NIBBLES)).
  - idx counts 0..NIBBLES-1 and never wraps in RUN; it is reset to 0 on accept.
  - All arithmetic is modulo 2^W; bits beyond the adder carry are discarded.

Test Plan:
- NIBBLES=4, sub=0, a=0x1234, b=0x4321 -> s=0x5555, cout=0, ovf=0; busy high for 4 cycles, done pulse in cycle 5 after the accept edge.
- sub=0, a=0xFFFF, b=0x0001 -> s=0x0000, cout=1, ovf=0; inter-nibble carry chain exercised on all 4 slices.
- sub=0, a=0x7FFF, b=0x0001 -> s=0x8000, cout=0, ovf=1. Then sub=1, a=0x8000, b=0x0001 -> s=0x7FFF, cout=1, ovf=1.
- sub=1, a=0x0005, b=0x0007 -> s=0xFFFE, cout=0 (borrow), ovf=0. Change a and b during RUN -> result unchanged.
- start pulsed again in RUN cycles 2 and 3 and in DONE -> ignored: single done pulse, s from the first operation. start held high -> accepts spaced exactly 6 cycles apart.
- rst_n=0 for one edge during RUN (after nibble 1) -> next cycle busy=0, done=0, s=0, cout=0, ovf=0, state IDLE. A new start then yields a correct result.
